pp_pipeline_accel_fifo_param: RTL and testbench
===============================================

Name: pp_pipeline_accel_fifo_param

Overview:
Generalised shift-register stream FIFO for the pp_pipeline_accel datapath. It supersedes the fixed-depth FIFO instances with one block that supports:
- any DEPTH >= 2, including non-powers-of-two
- any DATA_WIDTH
- programmable almost-full and almost-empty flags
- a synchronous flush
It sits between HLS dataflow processes on the if_write/if_read handshake, with the same show-ahead (FWFT) read semantics.

Parameters:
DATA_WIDTH, 64, payload width in bits (>=1).
DEPTH, 2, storage entries (>=2, any integer).
ADDR_WIDTH, $clog2(DEPTH), derived localparam; not overridden.
AF_MARGIN, 1, if_almost_full_n drops when count >= DEPTH-AF_MARGIN (1..DEPTH-1).
AE_MARGIN, 1, if_almost_empty_n drops when count <= AE_MARGIN (0..DEPTH-1).

Ports:
clk  in  1  rising-edge clock.
reset_n  in  1  asynchronous active-low reset.
if_flush  in  1  synchronous flush: discards all entries.
if_din  in  DATA_WIDTH  write data.
if_write  in  1  write request.
if_write_ce  in  1  write clock-enable; the write is effective only when if_write & if_write_ce.
if_full_n  out  1  1 = space available.
if_almost_full_n  out  1  0 = count >= DEPTH-AF_MARGIN.
if_read  in  1  read request.
if_read_ce  in  1  read clock-enable; the read is effective only when if_read & if_read_ce.
if_dout  out  DATA_WIDTH  oldest entry (show-ahead).
if_empty_n  out  1  1 = data available.
if_almost_empty_n  out  1  0 = count <= AE_MARGIN.
if_num_data_valid  out  ADDR_WIDTH+1  current occupancy.
if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

Behaviour:
- Reset (reset_n=0, async assert, sync deassert used by the system):
  - count=0, if_empty_n=0, if_full_n=1
  - if_almost_empty_n=0, if_almost_full_n = (DEPTH-AF_MARGIN > 0)
  - storage contents are not reset; if_dout is don't-care while empty
  - reset mid-operation drops all data immediately
- Effective operations: wr = if_write & if_write_ce & if_full_n; rd = if_read & if_read_ce & if_empty_n.
  - A write at full is ignored.
  - A read at empty is ignored and if_dout is undefined.
- Storage: shift array SRL[0..DEPTH-1].
  - On wr: SRL[0] <= if_din and SRL[i+1] <= SRL[i].
  - Read address = count-1 when count>0, else 0.
  - if_dout is a combinational mux of registers only; there is no path from if_din.
- Count update per cycle (one state register, count in 0..DEPTH):
  - wr & !rd: count+1.
  - rd & !wr: count-1.
  - wr & rd: count unchanged. Read data is the old oldest entry; the new word is appended.
  - At full with read and write: the write is gated by if_full_n, so only the read occurs (count DEPTH -> DEPTH-1).
  - At empty with read and write: only the write occurs (count 0 -> 1). if_dout shows the new word on the next cycle (1-cycle write-to-read latency).
- Flags are registered and updated in the same edge as count: if_empty_n = (count_next != 0), if_full_n = (count_next != DEPTH). Almost flags are decoded from count_next with the margins above. if_num_data_valid = count.
- Arithmetic: count is ADDR_WIDTH+1 bits and never wraps (guarded by the flags). Comparisons use DEPTH cast to ADDR_WIDTH+1 bits.
- if_flush=1 has priority over wr/rd that cycle: count<=0 and flags return to reset values. Same-cycle write data is discarded.
- Back-to-back: one read and one write can complete every cycle at any occupancy except the full and empty gating above.

Optional Feature:
Macro PP_FIFO_STATS_EN.
- Defined: adds ports if_stat_clr (in, 1), if_high_water (out, ADDR_WIDTH+1), if_overflow (out, 1), if_underflow (out, 1).
  - if_high_water: registered max of count since reset, flush or stat_clr.
  - if_overflow: sticky, set when if_write & if_write_ce while if_full_n=0.
  - if_underflow: sticky, set when if_read & if_read_ce while if_empty_n=0.
  - All three clear on reset_n=0 or if_stat_clr=1. stat_clr wins over a same-cycle set.
  - Flush clears only if_high_water.
- Undefined: these ports and their logic do not exist; the core behaviour is identical.

Test Plan:
1. DEPTH=5, AF_MARGIN=1, AE_MARGIN=1; write 0x11..0x55 on consecutive cycles -> if_almost_full_n=0 after the 4th write, if_full_n=0 after the 5th, if_num_data_valid=5. A 6th write is dropped and with STATS_EN sets if_overflow=1.
2. From full, assert read and write (din=0x66) together -> if_dout 0x11 is consumed, 0x66 is dropped, count=4, if_full_n=1.
3. Empty FIFO, assert read and write (din=0xA5) together -> count=1, if_empty_n=1 next cycle, if_dout=0xA5. Underflow is flagged (STATS_EN).
4. Occupancy 3 with continuous read+write for 10 cycles (din 0..9) -> count stays 3 and if_dout sequence is the old 3 entries then 0,1,...,6.
5. Occupancy 4, pulse if_flush together with a write -> count=0, if_empty_n=0, if_almost_empty_n=0. The next write of 0x77 reads back 0x77. if_high_water=0 after flush.
6. Occupancy 3, assert reset_n=0 mid-cycle (not at an edge) -> outputs reach reset values before the next edge. The stats sticky bits clear.

Source files
------------

// File: rtl/pp_pipeline_accel_fifo_param.sv
// Parameterised shift-register stream FIFO with show-ahead read, almost flags and flush.
// Optional occupancy/error statistics are enabled by defining PP_FIFO_STATS_EN.
module pp_pipeline_accel_fifo_param #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned AF_MARGIN  = 1,
  parameter int unsigned AE_MARGIN  = 1,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_flush,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  if_almost_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
`ifdef PP_FIFO_STATS_EN
  input  logic                  if_stat_clr,
  output logic [ADDR_WIDTH:0]   if_high_water,
  output logic                  if_overflow,
  output logic                  if_underflow,
`endif
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] DepthC    = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfThresh  = CntW'(DEPTH - AF_MARGIN);
  localparam logic [CntW-1:0] AeThresh  = CntW'(AE_MARGIN);
  localparam logic            AfRstVal  = (DEPTH > AF_MARGIN);

  logic [CntW-1:0] count_q, count_d;
  logic            empty_n_q, empty_n_d;
  logic            full_n_q, full_n_d;
  logic            afull_n_q, afull_n_d;
  logic            aempty_n_q, aempty_n_d;
  logic            wr, rd;

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [ADDR_WIDTH-1:0] raddr;

  assign wr = if_write & if_write_ce & full_n_q;
  assign rd = if_read & if_read_ce & empty_n_q;

  always_comb begin
    count_d = count_q;
    if (if_flush) begin
      count_d = '0;
    end else if (wr && !rd) begin
      count_d = count_q + 1'b1;
    end else if (rd && !wr) begin
      count_d = count_q - 1'b1;
    end
  end

  // Flags are decoded from the next count so they land on the same edge as the count itself.
  always_comb begin
    empty_n_d  = (count_d != '0);
    full_n_d   = (count_d != DepthC);
    afull_n_d  = !(count_d >= AfThresh);
    aempty_n_d = !(count_d <= AeThresh);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      empty_n_q  <= 1'b0;
      full_n_q   <= 1'b1;
      afull_n_q  <= AfRstVal;
      aempty_n_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      empty_n_q  <= empty_n_d;
      full_n_q   <= full_n_d;
      afull_n_q  <= afull_n_d;
      aempty_n_q <= aempty_n_d;
    end
  end

  // Storage is intentionally unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr && !if_flush) begin
      srl_q[0] <= if_din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  assign raddr = (count_q != '0) ? ADDR_WIDTH'(count_q - 1'b1) : '0;

  always_comb begin
    if_dout = srl_q[0];
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (raddr == ADDR_WIDTH'(i)) begin
        if_dout = srl_q[i];
      end
    end
  end

  assign if_full_n         = full_n_q;
  assign if_almost_full_n  = afull_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_almost_empty_n = aempty_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = DepthC;

`ifdef PP_FIFO_STATS_EN
  logic [CntW-1:0] high_water_q;
  logic            overflow_q, underflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_water_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else if (if_stat_clr) begin
      high_water_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (if_flush) begin
        high_water_q <= '0;
      end else if (count_d > high_water_q) begin
        high_water_q <= count_d;
      end
      if (if_write && if_write_ce && !full_n_q) begin
        overflow_q <= 1'b1;
      end
      if (if_read && if_read_ce && !empty_n_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign if_high_water = high_water_q;
  assign if_overflow   = overflow_q;
  assign if_underflow  = underflow_q;
`endif

  a_count_bound : assert property (@(posedge clk) disable iff (!reset_n) count_q <= DepthC);
  a_empty_flag  : assert property (@(posedge clk) disable iff (!reset_n)
                                   empty_n_q == (count_q != '0));
  a_full_flag   : assert property (@(posedge clk) disable iff (!reset_n)
                                   full_n_q == (count_q != DepthC));

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_param.sv
// Scoreboard bench for pp_pipeline_accel_fifo_param (DEPTH=5, 8-bit data); stats ports
// are exercised when PP_FIFO_STATS_EN is defined.
module tb_pp_pipeline_accel_fifo_param;

  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AW = $clog2(DEPTH);

  logic          clk;
  logic          reset_n;
  logic          if_flush;
  logic [DW-1:0] if_din;
  logic          if_write;
  logic          if_write_ce;
  logic          if_full_n;
  logic          if_almost_full_n;
  logic          if_read;
  logic          if_read_ce;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic          if_almost_empty_n;
  logic [AW:0]   if_num_data_valid;
  logic [AW:0]   if_fifo_cap;
`ifdef PP_FIFO_STATS_EN
  logic          if_stat_clr;
  logic [AW:0]   if_high_water;
  logic          if_overflow;
  logic          if_underflow;
`endif

  pp_pipeline_accel_fifo_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_MARGIN (1),
    .AE_MARGIN (1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .if_flush         (if_flush),
    .if_din           (if_din),
    .if_write         (if_write),
    .if_write_ce      (if_write_ce),
    .if_full_n        (if_full_n),
    .if_almost_full_n (if_almost_full_n),
    .if_read          (if_read),
    .if_read_ce       (if_read_ce),
    .if_dout          (if_dout),
    .if_empty_n       (if_empty_n),
    .if_almost_empty_n(if_almost_empty_n),
    .if_num_data_valid(if_num_data_valid),
`ifdef PP_FIFO_STATS_EN
    .if_stat_clr      (if_stat_clr),
    .if_high_water    (if_high_water),
    .if_overflow      (if_overflow),
    .if_underflow     (if_underflow),
`endif
    .if_fifo_cap      (if_fifo_cap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are applied just after a rising edge and held through the next one.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    if_write = w;
    if_din   = d;
    if_read  = r;
    if_flush = f;
    @(posedge clk);
    #1;
    if_write = 1'b0;
    if_read  = 1'b0;
    if_flush = 1'b0;
  endtask

  task automatic wr_push(input logic [DW-1:0] d);
    exp_q.push_back(d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  // Monitor: every effective read consumes the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && if_read && if_read_ce && if_empty_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read data", if_dout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("rd_data", if_dout, e);
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    if_flush    = 1'b0;
    if_din      = '0;
    if_write    = 1'b0;
    if_write_ce = 1'b1;
    if_read     = 1'b0;
    if_read_ce  = 1'b1;
`ifdef PP_FIFO_STATS_EN
    if_stat_clr = 1'b0;
`endif
    #22;
    check("rst_count", if_num_data_valid, 0);
    check("rst_empty_n", if_empty_n, 0);
    check("rst_full_n", if_full_n, 1);
    check("rst_aempty_n", if_almost_empty_n, 0);
    check("rst_afull_n", if_almost_full_n, 1);
    check("fifo_cap", if_fifo_cap, DEPTH);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, then one dropped write.
    wr_push(8'h11);
    wr_push(8'h22);
    wr_push(8'h33);
    wr_push(8'h44);
    check("t1_count4", if_num_data_valid, 4);
    check("t1_afull_n4", if_almost_full_n, 0);
    check("t1_full_n4", if_full_n, 1);
    wr_push(8'h55);
    check("t1_count5", if_num_data_valid, 5);
    check("t1_full_n5", if_full_n, 0);
    check("t1_aempty_n5", if_almost_empty_n, 1);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check("t1_count_drop", if_num_data_valid, 5);
`ifdef PP_FIFO_STATS_EN
    check("t1_overflow", if_overflow, 1);
    check("t1_underflow", if_underflow, 0);
`endif

    // Read+write at full: only the read happens.
    step(1'b1, 8'h66, 1'b1, 1'b0);
    check("t2_count", if_num_data_valid, 4);
    check("t2_full_n", if_full_n, 1);
    check("t2_dout", if_dout, 8'h22);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_drained", if_num_data_valid, 0);
    check("t2_empty_n", if_empty_n, 0);

    // Read+write at empty: only the write happens.
    exp_q.push_back(8'hA5);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("t3_count", if_num_data_valid, 1);
    check("t3_empty_n", if_empty_n, 1);
    check("t3_dout", if_dout, 8'hA5);
    check("t3_aempty_n", if_almost_empty_n, 0);
`ifdef PP_FIFO_STATS_EN
    check("t3_underflow", if_underflow, 1);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Steady-state streaming at occupancy 3.
    wr_push(8'hB1);
    wr_push(8'hB2);
    check("t4_aempty_n2", if_almost_empty_n, 1);
    wr_push(8'hB3);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'(i));
      step(1'b1, 8'(i), 1'b1, 1'b0);
    end
    check("t4_count", if_num_data_valid, 3);
    check("t4_dout", if_dout, 8'h07);

    // Flush at occupancy 4 with a same-cycle write.
    wr_push(8'hC4);
    check("t5_count4", if_num_data_valid, 4);
`ifdef PP_FIFO_STATS_EN
    check("t5_hw_pre", if_high_water, 5);
`endif
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    exp_q.delete();
    check("t5_count", if_num_data_valid, 0);
    check("t5_empty_n", if_empty_n, 0);
    check("t5_aempty_n", if_almost_empty_n, 0);
    check("t5_full_n", if_full_n, 1);
    check("t5_afull_n", if_almost_full_n, 1);
`ifdef PP_FIFO_STATS_EN
    check("t5_hw_post", if_high_water, 0);
    check("t5_overflow_kept", if_overflow, 1);
`endif
    wr_push(8'h77);
    check("t5_dout", if_dout, 8'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges at occupancy 3.
    wr_push(8'hD1);
    wr_push(8'hD2);
    wr_push(8'hD3);
    check("t6_count3", if_num_data_valid, 3);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_count", if_num_data_valid, 0);
    check("t6_empty_n", if_empty_n, 0);
    check("t6_full_n", if_full_n, 1);
    check("t6_aempty_n", if_almost_empty_n, 0);
    check("t6_afull_n", if_almost_full_n, 1);
`ifdef PP_FIFO_STATS_EN
    check("t6_overflow", if_overflow, 0);
    check("t6_underflow", if_underflow, 0);
    check("t6_hw", if_high_water, 0);
`endif
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    wr_push(8'hE1);
    check("t6_dout", if_dout, 8'hE1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("end_count", if_num_data_valid, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
